// File: rtl/pad_xcvr_pkg.sv
// Shared FSM state type and parity helper for the half-duplex pad transceiver.
// PAD_XCVR_PARITY_EN adds the TX_PAR/RX_PAR states.
package pad_xcvr_pkg;

    typedef enum logic [3:0] {
        IDLE,
        TX_START,
        TX_DATA,
`ifdef PAD_XCVR_PARITY_EN
        TX_PAR,
`endif
        TX_STOP,
        TURN,
        RX_WAIT,
        RX_START,
        RX_DATA,
`ifdef PAD_XCVR_PARITY_EN
        RX_PAR,
`endif
        RX_STOP
    } xcvr_state_t;

    // Bit that makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/pad_xcvr_sync.sv
// Two-flop synchronizer for the pad input; resets to the idle-high line level.
module pad_xcvr_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pad_half_duplex_xcvr.sv
// Half-duplex single-wire transceiver: send one byte, release the line, await one reply byte.
// Define PAD_XCVR_PARITY_EN for an even-parity bit after the data on both directions.
module pad_half_duplex_xcvr
    import pad_xcvr_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int TURN_BITS    = 2,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       pad_o,
    output logic       pad_t,
    input  logic       pad_i,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic       rx_perr,
    output logic       timeout,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(((TIMEOUT_BITS > TURN_BITS) ? TIMEOUT_BITS : TURN_BITS) + 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] TURN_LAST = BW'(TURN_BITS - 1);
    localparam logic [BW-1:0] TO_LAST   = BW'(TIMEOUT_BITS - 1);

    xcvr_state_t   state, state_nx;
    logic [CW-1:0] cyc_cnt, to_cyc;
    logic [BW-1:0] bit_cnt;
    logic [2:0]    bidx;
    logic [7:0]    tx_byte, rx_sr;
    logic          rdy, rx_s;
    logic          bit_end, half_pt, to_hit, in_wait, accept;

    pad_xcvr_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_i),
        .q     (rx_s)
    );

    assign tx_ready = rdy && (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = tx_valid && tx_ready;
    assign bit_end  = (cyc_cnt == CYC_LAST);
    assign half_pt  = (cyc_cnt == CYC_HALF);
    assign in_wait  = (state == RX_WAIT) || (state == RX_START);
    assign to_hit   = (to_cyc == CYC_LAST) && (bit_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pad_t    = 1'b1;
        pad_o    = 1'b1;
        case (state)
            IDLE:     if (accept) state_nx = TX_START;
            TX_START: begin
                pad_t = 1'b0;
                pad_o = 1'b0;
                if (bit_end) state_nx = TX_DATA;
            end
            TX_DATA: begin
                pad_t = 1'b0;
                pad_o = tx_byte[bidx];
`ifdef PAD_XCVR_PARITY_EN
                if (bit_end && bidx == 3'd7) state_nx = TX_PAR;
            end
            TX_PAR: begin
                pad_t = 1'b0;
                pad_o = even_parity(tx_byte);
                if (bit_end) state_nx = TX_STOP;
`else
                if (bit_end && bidx == 3'd7) state_nx = TX_STOP;
`endif
            end
            TX_STOP: begin
                pad_t = 1'b0;
                if (bit_end) state_nx = TURN;
            end
            TURN:     if (bit_end && bit_cnt == TURN_LAST) state_nx = RX_WAIT;
            // Timeout beats a fresh falling edge: only a confirmed start stops the clock.
            RX_WAIT: begin
                if (to_hit)     state_nx = IDLE;
                else if (!rx_s) state_nx = RX_START;
            end
            RX_START: begin
                if (half_pt && !rx_s) state_nx = RX_DATA;
                else if (to_hit)      state_nx = IDLE;
                else if (half_pt)     state_nx = RX_WAIT;
            end
            RX_DATA: begin
`ifdef PAD_XCVR_PARITY_EN
                if (bit_end && bidx == 3'd7) state_nx = RX_PAR;
            end
            RX_PAR: begin
                if (bit_end) state_nx = RX_STOP;
`else
                if (bit_end && bidx == 3'd7) state_nx = RX_STOP;
`endif
            end
            RX_STOP:  if (bit_end) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

`ifdef PAD_XCVR_PARITY_EN
    logic rx_par, perr_q;
    assign rx_perr = perr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_par <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            if (state == RX_PAR && bit_end) rx_par <= rx_s;
            if (state == RX_STOP && bit_end && rx_s) perr_q <= rx_par ^ even_parity(rx_sr);
        end
    end
`else
    assign rx_perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy      <= 1'b0;
            cyc_cnt  <= '0;
            to_cyc   <= '0;
            bit_cnt  <= '0;
            bidx     <= '0;
            tx_byte  <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            rdy      <= 1'b1;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            timeout  <= 1'b0;

            if (state_nx != state || bit_end || state == IDLE || state == RX_WAIT)
                cyc_cnt <= '0;
            else
                cyc_cnt <= cyc_cnt + 1'b1;

            if (state_nx != state)
                bidx <= '0;
            else if (bit_end && (state == TX_DATA || state == RX_DATA))
                bidx <= bidx + 1'b1;

            // bit_cnt times TURN, then is reused as the receive-window bit-time count;
            // a false start back to RX_WAIT must not clear it.
            if (!(in_wait || state == TURN) || state_nx == RX_WAIT && state == TURN) begin
                bit_cnt <= '0;
                to_cyc  <= '0;
            end else if (state == TURN) begin
                if (bit_end) bit_cnt <= bit_cnt + 1'b1;
            end else begin
                to_cyc <= (to_cyc == CYC_LAST) ? '0 : to_cyc + 1'b1;
                if (to_cyc == CYC_LAST) bit_cnt <= bit_cnt + 1'b1;
            end

            if (accept) tx_byte <= tx_data;
            if (state == RX_DATA && bit_end) rx_sr <= {rx_s, rx_sr[7:1]};

            if (state == RX_STOP && bit_end) begin
                if (rx_s) begin
                    rx_data  <= rx_sr;
                    rx_valid <= 1'b1;
                end else begin
                    rx_ferr  <= 1'b1;
                end
            end

            if (in_wait && state_nx == IDLE) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pad_half_duplex_xcvr.sv
// Directed + randomized bench for pad_half_duplex_xcvr (small bit timing).
// Honours PAD_XCVR_PARITY_EN when defined for the build.
module tb_pad_half_duplex_xcvr;

    localparam int CPB = 4;
    localparam int TRN = 2;
    localparam int TO  = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       pad_o, pad_t, pad_i;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ferr, rx_perr, timeout, busy;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_data    = 8'h00;

    pad_half_duplex_xcvr #(
        .CLKS_PER_BIT (CPB),
        .TURN_BITS    (TRN),
        .TIMEOUT_BITS (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .pad_o    (pad_o),
        .pad_t    (pad_t),
        .pad_i    (pad_i),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .rx_perr  (rx_perr),
        .timeout  (timeout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial frame as seen on the wire: start, data LSB first, optional even parity, stop.
    task automatic build_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                               output logic [10:0] bits, output int n);
        n = 0;
        bits = '0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin bits[n] = b[i]; n++; end
`ifdef PAD_XCVR_PARITY_EN
        bits[n] = (^b) ^ par_flip; n++;
`endif
        bits[n] = stop; n++;
    endtask

    // Ends on the negedge of the last TURN cycle; the next posedge enters RX_WAIT.
    task automatic send_byte(input logic [7:0] b);
        logic [10:0] bits;
        int          n;
        int          w;
        build_frame(b, 1'b0, 1'b1, bits, n);
        w = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        chk("tx_ready_idle", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                chk("tx_pad_t", pad_t, 0);
                chk("tx_pad_o", pad_o, bits[k]);
                chk("tx_ready_busy", tx_ready, 0);
            end
        end
        tx_valid = 1'b0;
        for (int c = 0; c < TRN * CPB; c++) begin
            @(negedge clk);
            chk("turn_pad_t", pad_t, 1);
            chk("turn_pad_o", pad_o, 1);
            chk("turn_busy", busy, 1);
        end
    endtask

    task automatic reply(input logic [7:0] b, input logic stop, input logic par_flip, input int dly);
        logic [10:0] bits;
        int          n;
        int          w;
        build_frame(b, par_flip, stop, bits, n);
        repeat (dly) @(negedge clk);
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            pad_i = bits[k];
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                chk("rx_quiet", {rx_valid, rx_ferr, timeout}, 0);
                chk("rx_pad_t", pad_t, 1);
                @(posedge clk); #1;
            end
        end
        pad_i = 1'b1;
        w = 0;
        @(negedge clk);
        while (busy !== 1'b0 && w < 40) begin @(negedge clk); w++; end
        chk("rx_end_bound", (w < 40), 1);
        if (stop) exp_data = b;
        chk("rx_valid", rx_valid, stop);
        chk("rx_ferr", rx_ferr, !stop);
        chk("rx_data", rx_data, exp_data);
`ifdef PAD_XCVR_PARITY_EN
        chk("rx_perr", rx_perr, stop & par_flip);
`else
        chk("rx_perr", rx_perr, 0);
`endif
        chk("rx_no_timeout", timeout, 0);
        chk("rx_tx_ready", tx_ready, 1);
        @(negedge clk);
        chk("rx_pulse_len", {rx_valid, rx_ferr, rx_perr}, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        pad_i    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pad", {pad_t, pad_o}, 2'b11);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_pulses", {rx_valid, rx_ferr, rx_perr, timeout}, 0);
        #2 rst_n = 1'b1;
        #1 chk("rel_tx_ready_before_edge", tx_ready, 0);
        @(posedge clk); #1;
        chk("rel_tx_ready_after_edge", tx_ready, 1);

        // Directed transmit and good reply
        send_byte(8'hA5);
        reply(8'h3C, 1'b1, 1'b0, $urandom_range(0, 4));

        // Framing error reply
        send_byte(8'($urandom));
        reply(8'($urandom), 1'b0, 1'b0, $urandom_range(0, 4));

        // Randomized traffic
        for (int t = 0; t < 4; t++) begin
            send_byte(8'($urandom));
`ifdef PAD_XCVR_PARITY_EN
            reply(8'($urandom), 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 6));
`else
            reply(8'($urandom), 1'b1, 1'b0, $urandom_range(0, 6));
`endif
        end

        // Glitch in the receive window, then no reply: timeout after TO*CPB cycles
        send_byte(8'($urandom));
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            chk("to_pulse", timeout, (i == TO * CPB + 1));
            chk("to_busy", busy, (i <= TO * CPB));
            chk("to_no_valid", rx_valid, 0);
            if (i == TO * CPB + 1) chk("to_rx_data", rx_data, exp_data);
            if (i == 3) pad_i = 1'b0;
            if (i == 4) pad_i = 1'b1;
        end

`ifdef PAD_XCVR_PARITY_EN
        // Parity mismatch still delivers the byte
        send_byte(8'($urandom));
        reply(8'h01, 1'b1, 1'b1, 2);
`endif

        // Reset in the middle of TX_DATA releases the pad without a clock edge
        @(negedge clk);
        chk("mid_ready", tx_ready, 1);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_pre_pad", {pad_t, pad_o}, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pad", {pad_t, pad_o}, 2'b11);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", tx_ready, 0);
        chk("mid_rst_rx_data", rx_data, 8'h00);
        #1 rst_n = 1'b1;
        #1 chk("mid_rel_ready_before_edge", tx_ready, 0);
        @(posedge clk); #1;
        chk("mid_rel_ready_after_edge", tx_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pad_half_duplex_xcvr.md
PAD_HALF_DUPLEX_XCVR -- requirements
Module: pad_half_duplex_xcvr

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (even, >=4).
REQ-002 SHALL have parameter TURN_BITS, default 2, meaning bit times the line is released between transmit stop bit and receive window.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 64, meaning bit times allowed in the receive window before a start bit.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports tx_data input 8, tx_valid input 1, tx_ready output 1: byte to send, with valid/ready handshake.
REQ-007 SHALL have ports pad_o output 1 (drives BB I), pad_t output 1 (drives BB T, 1 = released), pad_i input 1 (from BB O).
REQ-008 SHALL have ports rx_data output 8, rx_valid output 1, rx_ferr output 1, rx_perr output 1, timeout output 1, busy output 1.

Function
REQ-009 SHALL use FSM states IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP, TURN, RX_WAIT, RX_START, RX_DATA, RX_PAR, RX_STOP.
REQ-010 SHALL assert tx_ready only in IDLE; a byte is accepted on a cycle where tx_valid and tx_ready are both 1.
REQ-011 SHALL enter TX_START on the cycle after acceptance, with pad_t=0 and pad_o=0 for CLKS_PER_BIT cycles.
REQ-012 SHALL drive 8 data bits LSB first in TX_DATA, then pad_o=1 for one bit in TX_STOP; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-013 SHALL set pad_t=1 in every state except TX_START, TX_DATA, TX_PAR and TX_STOP, and keep pad_o=1 whenever pad_t=1.
REQ-014 SHALL stay in TURN for TURN_BITS*CLKS_PER_BIT cycles and then enter RX_WAIT.
REQ-015 SHALL pass pad_i through a two-flop synchronizer; all receive decisions use the synchronized value only.
REQ-016 SHALL move from RX_WAIT to RX_START when the synchronized line is 0.
REQ-017 SHALL resample at CLKS_PER_BIT/2 cycles into RX_START; on 1 (false start) it SHALL return to RX_WAIT without restarting the timeout counter.
REQ-018 SHALL sample each data bit (LSB first) and the stop bit at CLKS_PER_BIT-cycle intervals after the confirmed mid-start point.
REQ-019 SHALL, at the stop sample, load rx_data and pulse rx_valid for one cycle if stop=1, or pulse rx_ferr for one cycle if stop=0; both cases return to IDLE.
REQ-020 SHALL pulse timeout for one cycle and return to IDLE when TIMEOUT_BITS*CLKS_PER_BIT cycles elapse in RX_WAIT/RX_START without a confirmed start; rx_data is unchanged.
REQ-021 SHALL hold busy=1 in every state except IDLE.
REQ-022 SHALL ignore tx_valid outside IDLE; a transaction, once accepted, is never aborted except by reset.
REQ-023 SHALL size the bit-cycle counter as $clog2(CLKS_PER_BIT) bits and the bit-time counter as $clog2(max(TIMEOUT_BITS,TURN_BITS)+1) bits, with no wrap within a state.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE, pad_t=1, pad_o=1, tx_ready=0, busy=0, rx_data=8'h00, rx_valid=rx_ferr=rx_perr=timeout=0, and synchronizer flops=1.
REQ-025 SHALL raise tx_ready on the first rising clk edge after rst_n deasserts; reset mid-frame releases the pad immediately (asynchronously).

Configuration
REQ-026 SHALL, with PAD_XCVR_PARITY_EN defined, insert an even-parity bit after the 8th data bit on transmit (TX_PAR) and on receive (RX_PAR).
REQ-027 SHALL, with PAD_XCVR_PARITY_EN defined, pulse rx_perr together with rx_valid when received parity mismatches; rx_data still loads.
REQ-028 SHALL, without PAD_XCVR_PARITY_EN, omit TX_PAR/RX_PAR entirely and tie rx_perr to 0.

Structure
REQ-029 SHALL take the FSM state enum and the parity helper function from a shared package pad_xcvr_pkg.
REQ-030 SHALL contain one sub-module pad_xcvr_sync (two-flop synchronizer, reset value 1); no vendor primitives are instantiated inside the block.

Verification (CLKS_PER_BIT=4, TURN_BITS=2, TIMEOUT_BITS=8)
REQ-031 SHALL cover tx 8'hA5 -> pad_t=0 for 40 cycles, pad_o bits 0,1,0,1,0,0,1,0,1,1, then pad_t=1 and 8 TURN cycles.
REQ-032 SHALL cover far-end reply 8'h3C with stop=1 -> rx_data=8'h3C, one-cycle rx_valid, tx_ready=1 next cycle.
REQ-033 SHALL cover reply with stop=0 -> rx_ferr pulse, no rx_valid, return to IDLE.
REQ-034 SHALL cover a 1-cycle low glitch in RX_WAIT and no reply -> no rx_valid; timeout pulse exactly 32 cycles after RX_WAIT entry.
REQ-035 SHALL cover rst_n low during TX_DATA -> pad_t=1 and pad_o=1 with no clock edge; tx_ready=1 one edge after release.
REQ-036 SHALL cover, with PAD_XCVR_PARITY_EN, reply 8'h01 with parity bit 0 -> rx_valid and rx_perr pulse together, rx_data=8'h01.
